// File: rtl/piso_frame_tx_pkg.sv
// piso_frame_tx_pkg: shared constants for the serial frame transmitter.
//   - FSM state encodings (3-bit): IDLE=0, START=1, DATA=2, PARITY=3, STOP=4.
//     The matching receiver uses the same numbering.
//   - SO_IDLE: level of the serial line between frames.
//   - idx_width(): width of a counter that must hold 0..n-1, never less than 1 bit.
package piso_frame_tx_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

  localparam logic SO_IDLE = 1'b1;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/piso_frame_tx_bit_tick_gen.sv
// bit_tick_gen: serial bit timer.
//   Counts 0..BIT_CYCLES-1 and raises tick during the terminal-count cycle.
//   With BIT_CYCLES=1 tick is constant 1, so every cycle is a bit boundary.
// Ports:
//   clk   in  clock, posedge
//   rst   in  synchronous active-low reset, clears the counter
//   clear in  restart the count at 0 (used on handshake to align the frame)
//   tick  out one-cycle pulse at terminal count
module bit_tick_gen
  import piso_frame_tx_pkg::*;
#(
  parameter int BIT_CYCLES = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick
);

  localparam int CW = idx_width(BIT_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(BIT_CYCLES - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst || clear) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  assign tick = (BIT_CYCLES == 1) ? 1'b1 : (cnt == LAST);

endmodule

// File: rtl/piso_frame_tx.sv
// piso_frame_tx: parallel-in serial-out frame transmitter.
//   Accepts a word on a valid/ready handshake and sends it on so as
//   start(0), data LSB-first, optional parity, stop(1). so idles high.
// Handshake: a word transfers at a posedge where din_valid=1 and din_ready=1;
//   din_ready is high only while idle, so din/din_valid are ignored mid-frame.
// Ports:
//   clk        in   clock, posedge
//   rst        in   synchronous active-low reset
//   din        in   parallel word, sampled on handshake only
//   din_valid  in   din holds a word to send
//   din_ready  out  block accepts a word this cycle
//   so         out  serial line
//   busy       out  a frame is in progress
//   frame_done out  one-cycle pulse in the first idle cycle after STOP
//   fsm_state  out  current FSM state (debug visibility)
// All outputs except fsm_state are registered; fsm_state is the state register.
module piso_frame_tx
  import piso_frame_tx_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int PARITY_EN  = 1,
  parameter int PARITY_ODD = 0,
  parameter int BIT_CYCLES = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             so,
  output logic             busy,
  output logic             frame_done,
  output logic [2:0]       fsm_state
);

  localparam int IW = idx_width(WIDTH);
  localparam logic [IW-1:0] IDX_LAST = IW'(WIDTH - 1);

  logic [2:0]       state;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] shreg_nx;
  logic [IW-1:0]    idx;
  logic             par;
  logic             tick;
  logic             accept;

  // din_ready is only ever high in IDLE, so this implies state == ST_IDLE.
  assign accept    = din_valid && din_ready;
  assign shreg_nx  = shreg >> 1;
  assign fsm_state = state;

  bit_tick_gen #(
    .BIT_CYCLES(BIT_CYCLES)
  ) u_tick (
    .clk  (clk),
    .rst  (rst),
    .clear(accept),
    .tick (tick)
  );

  // so is registered: each transition loads the level of the bit being
  // entered, so the line changes exactly at the bit boundary.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= ST_IDLE;
      shreg      <= '0;
      idx        <= '0;
      par        <= 1'b0;
      so         <= SO_IDLE;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      din_ready  <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          din_ready <= 1'b1;
          if (accept) begin
            shreg     <= din;
            par       <= (^din) ^ (PARITY_ODD != 0);
            state     <= ST_START;
            so        <= 1'b0;
            busy      <= 1'b1;
            din_ready <= 1'b0;
          end
        end
        ST_START: begin
          if (tick) begin
            state <= ST_DATA;
            so    <= shreg[0];
            idx   <= '0;
          end
        end
        ST_DATA: begin
          if (tick) begin
            if (idx == IDX_LAST) begin
              if (PARITY_EN != 0) begin
                state <= ST_PARITY;
                so    <= par;
              end else begin
                state <= ST_STOP;
                so    <= SO_IDLE;
              end
            end else begin
              // Present the next bit now; shreg[0] always holds the bit on so.
              idx   <= idx + IW'(1);
              shreg <= shreg_nx;
              so    <= shreg_nx[0];
            end
          end
        end
        ST_PARITY: begin
          if (tick) begin
            state <= ST_STOP;
            so    <= SO_IDLE;
          end
        end
        ST_STOP: begin
          if (tick) begin
            state      <= ST_IDLE;
            so         <= SO_IDLE;
            busy       <= 1'b0;
            frame_done <= 1'b1;
            din_ready  <= 1'b1;
          end
        end
        default: begin
          state     <= ST_IDLE;
          so        <= SO_IDLE;
          busy      <= 1'b0;
          din_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_piso_frame_tx.sv
// Testbench for piso_frame_tx. Five instances cover the parameter corners:
//   0: defaults (8 bits, even parity, 1 cycle/bit)
//   1: odd parity
//   2: no parity
//   3: 4 cycles/bit
//   4: 1 data bit, even parity, 2 cycles/bit
// Expected frames are hand-written bit vectors (bit k = k-th bit on the line).
module tb_piso_frame_tx;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] din_a      [5];
  logic       din_valid  [5];
  logic       din_ready  [5];
  logic       so         [5];
  logic       busy       [5];
  logic       frame_done [5];
  logic [2:0] st         [5];

  int n_cmp = 0;
  int n_err = 0;

  // ---------------- clock / reset block ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  piso_frame_tx u0 (
    .clk(clk), .rst(rst), .din(din_a[0]), .din_valid(din_valid[0]),
    .din_ready(din_ready[0]), .so(so[0]), .busy(busy[0]),
    .frame_done(frame_done[0]), .fsm_state(st[0]));

  piso_frame_tx #(.PARITY_ODD(1)) u1 (
    .clk(clk), .rst(rst), .din(din_a[1]), .din_valid(din_valid[1]),
    .din_ready(din_ready[1]), .so(so[1]), .busy(busy[1]),
    .frame_done(frame_done[1]), .fsm_state(st[1]));

  piso_frame_tx #(.PARITY_EN(0)) u2 (
    .clk(clk), .rst(rst), .din(din_a[2]), .din_valid(din_valid[2]),
    .din_ready(din_ready[2]), .so(so[2]), .busy(busy[2]),
    .frame_done(frame_done[2]), .fsm_state(st[2]));

  piso_frame_tx #(.BIT_CYCLES(4)) u3 (
    .clk(clk), .rst(rst), .din(din_a[3]), .din_valid(din_valid[3]),
    .din_ready(din_ready[3]), .so(so[3]), .busy(busy[3]),
    .frame_done(frame_done[3]), .fsm_state(st[3]));

  piso_frame_tx #(.WIDTH(1), .BIT_CYCLES(2)) u4 (
    .clk(clk), .rst(rst), .din(din_a[4][0]), .din_valid(din_valid[4]),
    .din_ready(din_ready[4]), .so(so[4]), .busy(busy[4]),
    .frame_done(frame_done[4]), .fsm_state(st[4]));

  // ---------------- scoreboard ----------------
  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Repeat each of nbits frame bits bc times to get the per-cycle line image.
  function automatic logic [63:0] stretch(input logic [63:0] bits, input int nbits, input int bc);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < nbits; i++)
      for (int j = 0; j < bc; j++)
        r[i*bc + j] = bits[i];
    return r;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic start_frame(input int id, input logic [7:0] word);
    @(negedge clk);
    check_eq("ready_before_send", 64'(din_ready[id]), 64'd1);
    din_a[id]     = word;
    din_valid[id] = 1'b1;
    @(posedge clk);
    #1 din_valid[id] = 1'b0;
  endtask

  // Sample so for len cycles after the handshake edge; bad counts cycles where
  // busy/frame_done/din_ready disagree with "frame in progress".
  task automatic capture(input int id, input int len, output logic [63:0] seq, output int bad);
    seq = '0;
    bad = 0;
    for (int k = 0; k < len; k++) begin
      @(negedge clk);
      seq[k] = so[id];
      if (busy[id] !== 1'b1 || frame_done[id] !== 1'b0 || din_ready[id] !== 1'b0) bad++;
    end
  endtask

  task automatic finish_frame(input int id);
    @(negedge clk);
    check_eq("end_frame_done", 64'(frame_done[id]), 64'd1);
    check_eq("end_busy", 64'(busy[id]), 64'd0);
    check_eq("end_ready", 64'(din_ready[id]), 64'd1);
    check_eq("end_so_idle", 64'(so[id]), 64'd1);
    @(negedge clk);
    check_eq("frame_done_one_cycle", 64'(frame_done[id]), 64'd0);
  endtask

  task automatic run_frame(input int id, input logic [7:0] word, input int len,
                           input logic [63:0] exp, input string tag);
    logic [63:0] seq;
    int bad;
    start_frame(id, word);
    capture(id, len, seq, bad);
    check_eq(tag, seq, exp);
    check_eq({tag, "_flags"}, 64'(bad), 64'd0);
    finish_frame(id);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [63:0] seq;
    int bad;
    for (int i = 0; i < 5; i++) begin
      din_a[i]     = 8'h00;
      din_valid[i] = 1'b0;
    end

    // Reset values
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("rst_so", 64'(so[0]), 64'd1);
    check_eq("rst_busy", 64'(busy[0]), 64'd0);
    check_eq("rst_frame_done", 64'(frame_done[0]), 64'd0);
    check_eq("rst_ready", 64'(din_ready[0]), 64'd0);
    rst = 1'b1;
    @(negedge clk);
    check_eq("rel_ready", 64'(din_ready[0]), 64'd1);
    check_eq("rel_ready_b4", 64'(din_ready[3]), 64'd1);

    // Frame content, defaults: A5 -> 0,1,0,1,0,0,1,0,1,0,1
    run_frame(0, 8'hA5, 11, stretch(64'b10101001010, 11, 1), "frame_a5");
    // Even parity on 01 -> parity 1
    run_frame(0, 8'h01, 11, stretch(64'b11000000010, 11, 1), "even_par_01");
    // Odd parity on 01 -> parity 0
    run_frame(1, 8'h01, 11, stretch(64'b10000000010, 11, 1), "odd_par_01");
    // No parity: 10-cycle frame
    run_frame(2, 8'hA5, 10, stretch(64'b1101001010, 10, 1), "nopar_a5");
    // Bit stretching: 3C, 4 cycles per bit, 44 cycles
    run_frame(3, 8'h3C, 44, stretch(64'b10001111000, 11, 4), "stretch_3c");
    // WIDTH=1: din=1 -> 0,1,parity 1,1 each held 2 cycles
    run_frame(4, 8'h01, 8, stretch(64'b1110, 4, 2), "w1_d1");
    run_frame(4, 8'h00, 8, stretch(64'b1000, 4, 2), "w1_d0");

    // Back-to-back with din_valid held high: 55 then AA
    @(negedge clk);
    check_eq("b2b_ready", 64'(din_ready[0]), 64'd1);
    din_a[0]     = 8'h55;
    din_valid[0] = 1'b1;
    @(posedge clk);
    #1 din_a[0] = 8'hAA;
    capture(0, 11, seq, bad);
    check_eq("b2b_frame_55", seq, stretch(64'b10010101010, 11, 1));
    check_eq("b2b_flags1", 64'(bad), 64'd0);
    @(negedge clk);
    check_eq("b2b_gap_so", 64'(so[0]), 64'd1);
    check_eq("b2b_gap_done", 64'(frame_done[0]), 64'd1);
    check_eq("b2b_gap_ready", 64'(din_ready[0]), 64'd1);
    @(posedge clk);
    #1 din_valid[0] = 1'b0;
    capture(0, 11, seq, bad);
    check_eq("b2b_frame_aa", seq, stretch(64'b10101010100, 11, 1));
    check_eq("b2b_flags2", 64'(bad), 64'd0);
    finish_frame(0);

    // Input isolation while busy
    start_frame(0, 8'hA5);
    fork
      capture(0, 11, seq, bad);
      begin
        repeat (2) @(negedge clk);
        din_a[0] = 8'h00; din_valid[0] = 1'b1;
        @(negedge clk);
        din_a[0] = 8'hFF; din_valid[0] = 1'b0;
        @(negedge clk);
        din_a[0] = 8'h5A; din_valid[0] = 1'b1;
        @(negedge clk);
        din_valid[0] = 1'b0;
      end
    join
    check_eq("iso_frame", seq, stretch(64'b10101001010, 11, 1));
    check_eq("iso_flags", 64'(bad), 64'd0);
    finish_frame(0);

    // Reset mid-frame during DATA bit 3 (C3: bit3 = 0)
    start_frame(0, 8'hC3);
    repeat (5) @(negedge clk);
    check_eq("mid_data_bit3", 64'(so[0]), 64'd0);
    check_eq("mid_busy", 64'(busy[0]), 64'd1);
    rst = 1'b0;
    din_a[0] = 8'h77; din_valid[0] = 1'b1;
    @(negedge clk);
    check_eq("mrst_so", 64'(so[0]), 64'd1);
    check_eq("mrst_busy", 64'(busy[0]), 64'd0);
    check_eq("mrst_done", 64'(frame_done[0]), 64'd0);
    check_eq("mrst_ready", 64'(din_ready[0]), 64'd0);
    @(negedge clk);
    check_eq("mrst2_so", 64'(so[0]), 64'd1);
    check_eq("mrst2_busy", 64'(busy[0]), 64'd0);
    rst = 1'b1;
    din_valid[0] = 1'b0;
    @(negedge clk);
    check_eq("mrel_ready", 64'(din_ready[0]), 64'd1);
    check_eq("mrel_busy", 64'(busy[0]), 64'd0);
    check_eq("mrel_done", 64'(frame_done[0]), 64'd0);
    check_eq("mrel_so", 64'(so[0]), 64'd1);
    // F0 -> 0, 0,0,0,0,1,1,1,1, parity 0, 1
    run_frame(0, 8'hF0, 11, stretch(64'b10111100000, 11, 1), "post_rst_f0");

    // ---------------- final report ----------------
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
